hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/pipeline_pkg.sv | 30 +++
 rtl/sb_match.sv | 22 ++
 rtl/hazard_scoreboard.sv | 87 ++++++++
 tb/tb_hazard_scoreboard.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared pipeline opcodes, scoreboard slot type and slot count
package pipeline_pkg;

    localparam int SB_SLOTS = 3;
    localparam int SB_EX    = 0;
    localparam int SB_MEM   = 1;
    localparam int SB_WB    = 2;

    // RV32I major opcodes as seen in instr[6:2]
    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_OP_IMM = 5'b00100;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_OP     = 5'b01100;
    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_JAL    = 5'b11011;
    localparam logic [4:0] OPC_SYSTEM = 5'b11100;

    typedef struct packed {
        logic       vld;
        logic [4:0] rd;
    } sb_slot_t;

    function automatic logic opc_uses_rs1(input logic [4:0] opc);
        return !(opc == OPC_LUI || opc == OPC_AUIPC || opc == OPC_JAL);
    endfunction

endpackage

// File: rtl/sb_match.sv
// rtl/sb_match.sv - compares one tracked destination against the ID source registers
module sb_match
    import pipeline_pkg::*;
(
    input  sb_slot_t   slot,
    input  logic [4:0] rs1,
    input  logic [4:0] rs2,
    input  logic       rs1_used,
    input  logic       rs2_used,
    output logic       match
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit = rs1_used && (rs1 == slot.rd);
    assign rs2_hit = rs2_used && (rs2 == slot.rd);

    // rd != 0 also rules out x0 as a source, since a hit needs rs == rd
    assign match = slot.vld && (slot.rd != 5'd0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - ID-stage RAW hazard scoreboard; HAZARD_WB_BYPASS_EN drops WB from compare
module hazard_scoreboard
    import pipeline_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] instr_i,
    input  logic        id_valid_i,
    input  logic        rd_wren_i,
    input  logic        is_rs2_i,
    input  logic        br_flush_i,
    output logic        stall_o,
    output logic        bubble_o,
    output logic [31:0] stall_cnt_o
);

`ifdef HAZARD_WB_BYPASS_EN
    localparam int CMP_SLOTS = SB_SLOTS - 1;
`else
    localparam int CMP_SLOTS = SB_SLOTS;
`endif

    sb_slot_t             slot_q [SB_SLOTS];
    sb_slot_t             ex_next;
    logic [31:0]          stall_cnt_q;
    logic [CMP_SLOTS-1:0] slot_match;
    logic [4:0]           rs1;
    logic [4:0]           rs2;
    logic [4:0]           rd;
    logic                 rs1_used;
    logic                 rs2_used;
    logic                 hazard;
    logic                 unused_instr_bits;

    assign rs1      = instr_i[19:15];
    assign rs2      = instr_i[24:20];
    assign rd       = instr_i[11:7];
    assign rs1_used = opc_uses_rs1(instr_i[6:2]);
    assign rs2_used = is_rs2_i;

    assign unused_instr_bits = ^{instr_i[31:25], instr_i[14:12], instr_i[1:0]};

    for (genvar g = 0; g < CMP_SLOTS; g++) begin : g_cmp
        sb_match u_match (
            .slot     (slot_q[g]),
            .rs1      (rs1),
            .rs2      (rs2),
            .rs1_used (rs1_used),
            .rs2_used (rs2_used),
            .match    (slot_match[g])
        );
    end

    // A taken branch kills ID, so its hazard is irrelevant
    assign hazard   = id_valid_i && (|slot_match);
    assign stall_o  = hazard && !br_flush_i;
    assign bubble_o = stall_o || br_flush_i || !id_valid_i;

    always_comb begin
        ex_next = '0;
        if (!bubble_o) begin
            ex_next.vld = rd_wren_i && (rd != 5'd0);
            ex_next.rd  = rd;
        end
    end

    // Stages past ID never stall, so slots advance every cycle
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int i = 0; i < SB_SLOTS; i++) begin
                slot_q[i] <= '0;
            end
            stall_cnt_q <= '0;
        end else begin
            for (int i = SB_SLOTS - 1; i > 0; i--) begin
                slot_q[i] <= slot_q[i-1];
            end
            slot_q[SB_EX] <= ex_next;
            if (stall_o && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - table-driven and sequence checks for hazard_scoreboard
module tb_hazard_scoreboard;

`ifdef HAZARD_WB_BYPASS_EN
    localparam int NW = 2;
`else
    localparam int NW = 3;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr;
    logic        valid;
    logic        wren;
    logic        is_rs2;
    logic        flush;
    logic        stall;
    logic        bubble;
    logic [31:0] cnt;

    int nvec = 0;
    int nmis = 0;

    always #5 clk = ~clk;

    hazard_scoreboard dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .instr_i     (instr),
        .id_valid_i  (valid),
        .rd_wren_i   (wren),
        .is_rs2_i    (is_rs2),
        .br_flush_i  (flush),
        .stall_o     (stall),
        .bubble_o    (bubble),
        .stall_cnt_o (cnt)
    );

    typedef struct {
        logic        rst_n;
        logic [31:0] instr;
        logic        valid;
        logic        wren;
        logic        is_rs2;
        logic        flush;
        logic        exp_stall;
        logic        exp_bubble;
        logic [31:0] exp_cnt;
    } vec_t;

    function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rs2_f,
                                           input logic [4:0] rs1_f, input logic [4:0] rd_f);
        return {f7, rs2_f, rs1_f, 3'b000, rd_f, 7'b0110011};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [31:0] in, input logic v, input logic w,
                         input logic s2, input logic f);
        @(negedge clk);
        rst_n = r; instr = in; valid = v; wren = w; is_rs2 = s2; flush = f;
        #1;
    endtask

    task automatic do_reset();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    logic [31:0] add_x5, sub_x6, addi_x0, add_x7, add_x8, lw_x8, sw_x8, lui_x8, lui_x9;
    logic [31:0] add_x10, auipc_x11, jal_x1;
    vec_t tbl [12];

    initial begin
        add_x5    = r_type(7'b0000000, 5'd2, 5'd1, 5'd5);
        sub_x6    = r_type(7'b0100000, 5'd3, 5'd5, 5'd6);
        addi_x0   = {12'd1, 5'd1, 3'b000, 5'd0, 7'b0010011};
        add_x7    = r_type(7'b0000000, 5'd0, 5'd0, 5'd7);
        add_x8    = r_type(7'b0000000, 5'd6, 5'd7, 5'd8);
        lw_x8     = {12'd0, 5'd2, 3'b010, 5'd8, 7'b0000011};
        sw_x8     = {7'd0, 5'd8, 5'd3, 3'b010, 5'd4, 7'b0100011};
        lui_x8    = {20'd1, 5'd8, 7'b0110111};
        lui_x9    = {20'h00040, 5'd9, 7'b0110111};
        add_x10   = r_type(7'b0000000, 5'd8, 5'd9, 5'd10);
        auipc_x11 = {12'd0, 5'd9, 3'b000, 5'd11, 7'b0010111};
        jal_x1    = {12'd0, 5'd11, 3'b000, 5'd1, 7'b1101111};

        //          rst   instr      v     w     rs2   fl    stall bub   cnt
        tbl[0]  = '{1'b1, sub_x6,    1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0};
        tbl[1]  = '{1'b1, addi_x0,   1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0};
        tbl[2]  = '{1'b1, add_x7,    1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0};
        tbl[3]  = '{1'b1, add_x8,    1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'd0};
        tbl[4]  = '{1'b1, lw_x8,     1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0};
        tbl[5]  = '{1'b1, sw_x8,     1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'd0};
        tbl[6]  = '{1'b1, sw_x8,     1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'd1};
        tbl[7]  = '{1'b1, lui_x8,    1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd1};
        tbl[8]  = '{1'b1, lui_x9,    1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd1};
        tbl[9]  = '{1'b1, add_x10,   1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'd1};
        tbl[10] = '{1'b1, auipc_x11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd1};
        tbl[11] = '{1'b1, jal_x1,    1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd1};

        do_reset();
        check("reset_cnt", cnt, 32'd0);
        check("reset_stall", {31'd0, stall}, 32'd0);

        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].rst_n, tbl[i].instr, tbl[i].valid, tbl[i].wren, tbl[i].is_rs2, tbl[i].flush);
            check($sformatf("tbl%0d_stall", i), {31'd0, stall}, {31'd0, tbl[i].exp_stall});
            check($sformatf("tbl%0d_bubble", i), {31'd0, bubble}, {31'd0, tbl[i].exp_bubble});
            check($sformatf("tbl%0d_cnt", i), cnt, tbl[i].exp_cnt);
        end

        // back-to-back dependent pair: add x5 then sub x6,x5,x3
        do_reset();
        drive(1'b1, add_x5, 1'b1, 1'b1, 1'b1, 1'b0);
        check("dep_producer_stall", {31'd0, stall}, 32'd0);
        for (int k = 0; k < NW; k++) begin
            drive(1'b1, sub_x6, 1'b1, 1'b1, 1'b1, 1'b0);
            check($sformatf("dep_stall%0d", k), {31'd0, stall}, 32'd1);
            check($sformatf("dep_bubble%0d", k), {31'd0, bubble}, 32'd1);
            check($sformatf("dep_cnt%0d", k), cnt, k);
        end
        drive(1'b1, sub_x6, 1'b1, 1'b1, 1'b1, 1'b0);
        check("dep_release_stall", {31'd0, stall}, 32'd0);
        check("dep_release_bubble", {31'd0, bubble}, 32'd0);
        check("dep_total_cnt", cnt, NW);

        // reset pulsed during the second stall cycle
        do_reset();
        drive(1'b1, add_x5, 1'b1, 1'b1, 1'b1, 1'b0);
        drive(1'b1, sub_x6, 1'b1, 1'b1, 1'b1, 1'b0);
        check("rst_mid_stall1", {31'd0, stall}, 32'd1);
        drive(1'b0, sub_x6, 1'b1, 1'b1, 1'b1, 1'b0);
        check("rst_mid_stall2", {31'd0, stall}, 32'd1);
        drive(1'b1, sub_x6, 1'b1, 1'b1, 1'b1, 1'b0);
        check("rst_after_stall", {31'd0, stall}, 32'd0);
        check("rst_after_bubble", {31'd0, bubble}, 32'd0);
        check("rst_after_cnt", cnt, 32'd0);

        // counter saturation
        do_reset();
        drive(1'b1, add_x5, 1'b1, 1'b1, 1'b1, 1'b0);
        force dut.stall_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cnt_q;
        drive(1'b1, sub_x6, 1'b1, 1'b1, 1'b1, 1'b0);
        check("sat_preload", cnt, 32'hFFFF_FFFE);
        check("sat_stall0", {31'd0, stall}, 32'd1);
        drive(1'b1, sub_x6, 1'b1, 1'b1, 1'b1, 1'b0);
        check("sat_cnt1", cnt, 32'hFFFF_FFFF);
        check("sat_stall1", {31'd0, stall}, 32'd1);
        for (int k = 2; k <= NW; k++) begin
            drive(1'b1, sub_x6, 1'b1, 1'b1, 1'b1, 1'b0);
            check($sformatf("sat_cnt%0d", k), cnt, 32'hFFFF_FFFF);
        end
        drive(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("sat_hold", cnt, 32'hFFFF_FFFF);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
